// File: rtl/dual_port_ram_rd_arbiter_pkg.sv
// Shared definitions for the dual_port_ram read-port arbiter.
package dual_port_ram_arb_pkg;

  localparam int MIN_REQ_CNT = 2;
  localparam int MAX_REQ_CNT = 16;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_w(input int req_cnt);
    return (req_cnt > 1) ? $clog2(req_cnt) : 1;
  endfunction

endpackage

// File: rtl/dual_port_ram_rd_arbiter_if.sv
// Requester-side bus: packed per-requester requests, one-hot grants and responses.
interface dual_port_ram_rd_arbiter_if #(
  parameter int REQ_CNT    = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);
  logic [REQ_CNT-1:0]            req_valid;
  logic [REQ_CNT*ADDR_WIDTH-1:0] req_addr;
  logic [REQ_CNT-1:0]            req_ready;
  logic [REQ_CNT-1:0]            resp_valid;
  logic [DATA_WIDTH-1:0]         resp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: write port plus a read port with optional output register.
module dual_port_ram #(
  parameter int ADDR_WIDTH        = 5,
  parameter int DATA_WIDTH        = 8,
  parameter bit REGISTERED_OUTPUT = 1'b0
) (
  input  logic                  wr_clk_i,
  input  logic                  wr_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_clk_i,
  input  logic                  rd_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                  output_reg_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [DATA_WIDTH-1:0] r_out_data;

  always_ff @(posedge wr_clk_i) begin
    if (wr_i) r_mem[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge rd_clk_i) begin
    if (rd_i) r_rd_data <= r_mem[rd_addr_i];
  end

  always_ff @(posedge rd_clk_i) begin
    if (output_reg_en_i) r_out_data <= r_rd_data;
  end

  assign rd_data_o = REGISTERED_OUTPUT ? r_out_data : r_rd_data;

endmodule

// File: rtl/dual_port_ram_rd_arbiter_rr_arbiter.sv
// Round-robin grant logic; owns the priority pointer, which advances past each accepted winner.
module rr_arbiter
  import dual_port_ram_arb_pkg::*;
#(
  parameter int  REQ_CNT = 4,
  localparam int IDX_W   = idx_w(REQ_CNT)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [REQ_CNT-1:0] i_req,
  input  logic               i_accept,
  output logic [REQ_CNT-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx
);
  logic [IDX_W-1:0] r_ptr;

  // Search from the pointer upward; wrap is explicit so non-power-of-2 counts stay in range.
  always_comb begin
    logic [IDX_W:0] w_k;
    logic           w_found;
    o_grant     = '0;
    o_grant_idx = '0;
    w_k         = '0;
    w_found     = 1'b0;
    for (int i = 0; i < REQ_CNT; i++) begin
      w_k = {1'b0, r_ptr} + (IDX_W+1)'(i);
      if (w_k >= (IDX_W+1)'(REQ_CNT)) w_k = w_k - (IDX_W+1)'(REQ_CNT);
      if (!w_found && i_req[w_k[IDX_W-1:0]]) begin
        w_found                   = 1'b1;
        o_grant[w_k[IDX_W-1:0]]   = 1'b1;
        o_grant_idx               = w_k[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (i_accept) begin
      r_ptr <= (o_grant_idx == IDX_W'(REQ_CNT-1)) ? '0 : o_grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/dual_port_ram_rd_arbiter.sv
// Shares one dual_port_ram read port among REQ_CNT requesters and routes each
// read's data back to its originator through a RAM_LATENCY-deep tag pipeline.
module dual_port_ram_rd_arbiter
  import dual_port_ram_arb_pkg::*;
#(
  parameter int REQ_CNT     = 4,
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 8,
  parameter int RAM_LATENCY = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  dual_port_ram_rd_arbiter_if.slave bus,
  output logic [ADDR_WIDTH-1:0]   ram_rd_addr_o,
  output logic                    ram_rd_o,
  output logic                    ram_output_reg_en_o,
  input  logic [DATA_WIDTH-1:0]   ram_rd_data_i
);
  localparam int IDX_W = idx_w(REQ_CNT);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  generate
    if (RAM_LATENCY != 1 && RAM_LATENCY != 2) begin : g_bad_latency
      $error("dual_port_ram_rd_arbiter: RAM_LATENCY must be 1 or 2");
    end
    if (REQ_CNT < MIN_REQ_CNT || REQ_CNT > MAX_REQ_CNT) begin : g_bad_req_cnt
      $error("dual_port_ram_rd_arbiter: REQ_CNT must be 2..16");
    end
  endgenerate

  logic [REQ_CNT-1:0]         w_grant;
  logic [IDX_W-1:0]           w_gidx;
  logic                       w_accept;
  tag_t [RAM_LATENCY-1:0]     r_tag;
  tag_t                       w_last;

  rr_arbiter #(.REQ_CNT(REQ_CNT)) u_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_req       (bus.req_valid),
    .i_accept    (w_accept),
    .o_grant     (w_grant),
    .o_grant_idx (w_gidx)
  );

  assign bus.req_ready = rst_i ? '0 : w_grant;
  assign w_accept      = |(bus.req_valid & bus.req_ready);

  assign ram_rd_o      = w_accept;
  assign ram_rd_addr_o = w_accept ? bus.req_addr[w_gidx*ADDR_WIDTH +: ADDR_WIDTH] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tag <= '0;
    end else begin
      r_tag[0] <= '{valid: w_accept, idx: w_gidx};
      for (int i = 1; i < RAM_LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign w_last = r_tag[RAM_LATENCY-1];

  always_comb begin
    bus.resp_valid = '0;
    if (w_last.valid && !rst_i) bus.resp_valid[w_last.idx] = 1'b1;
  end

  assign bus.resp_data = ram_rd_data_i;

  // With a registered RAM the output stage only loads when a real read is one cycle in.
  assign ram_output_reg_en_o = (RAM_LATENCY == 2) ? r_tag[0].valid : 1'b1;

endmodule
